// File: rtl/iccm_loader_pkg.sv
// iccm_loader_pkg: shared constants and state encoding for the ICCM boot loader
package iccm_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] WE_FULL = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    FILL = S_FILL,
    WRITE = S_WRITE,
    RD_REQ = S_RD_REQ,
    RD_WAIT = S_RD_WAIT,
    DONE = S_DONE
  } loader_state_e;
endpackage

// File: rtl/iccm_loader_if.sv
// iccm_loader_if: control, byte-stream and ICCM port bundle of the boot loader
//   master: loader side (drives s_ready, status, mem_* requests)
//   slave : environment side (drives start/config, byte stream, ICCM read return)
interface iccm_loader_if #(parameter int ADDR_W = 12);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0] num_words;
  logic s_valid;
  logic [7:0] s_data;
  logic s_ready;
  logic busy;
  logic done;
  logic error;
  logic [ADDR_W-1:0] err_addr;
  logic [31:0] checksum;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_we;
  logic [31:0] mem_rdata;
  logic mem_rvalid;
  modport master (
    input start, base_addr, num_words, s_valid, s_data, mem_rdata, mem_rvalid,
    output s_ready, busy, done, error, err_addr, checksum, mem_req, mem_addr, mem_wdata, mem_we
  );
  modport slave (
    output start, base_addr, num_words, s_valid, s_data, mem_rdata, mem_rvalid,
    input s_ready, busy, done, error, err_addr, checksum, mem_req, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/iccm_byte_packer.sv
// iccm_byte_packer: packs accepted stream bytes little-endian into 32-bit words
//   clock_i, flush_i (clears byte count and word), en_i (accept window),
//   s_valid_i/s_data_i/s_ready_o byte stream, word_valid_o, word_o
module iccm_byte_packer
  import iccm_loader_pkg::*;
(
  input  logic clock_i,
  input  logic flush_i,
  input  logic en_i,
  input  logic s_valid_i,
  input  logic [7:0] s_data_i,
  output logic s_ready_o,
  output logic word_valid_o,
  output logic [8*WORD_BYTES-1:0] word_o
);
  localparam int CW = $clog2(WORD_BYTES);
  logic [CW-1:0] cnt_q;
  logic [8*WORD_BYTES-1:0] word_q;
  logic acc;
  assign s_ready_o = en_i;
  assign acc = en_i && s_valid_i;
  // Fires while the last byte is being accepted; word_o is complete from the next cycle.
  assign word_valid_o = acc && cnt_q == CW'(WORD_BYTES - 1);
  assign word_o = word_q;
  // Shifting in at the top lands the first byte in [7:0] after a full word.
  always_ff @(posedge clock_i) begin
    if (flush_i) begin
      cnt_q <= '0;
      word_q <= '0;
    end else if (acc) begin
      cnt_q <= cnt_q + CW'(1);
      word_q <= {s_data_i, word_q[8*WORD_BYTES-1:8]};
    end
  end
endmodule

// File: rtl/iccm_loader.sv
// iccm_loader: streams boot bytes into consecutive ICCM words with an additive checksum
//   clock, reset (sync, active-high), bus (iccm_loader_if.master: start/config,
//   byte stream, status, ICCM request port)
//   ICCM_LOADER_VERIFY_EN: read back all words and compare their sum, with read timeout
module iccm_loader
  import iccm_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 8
) (
  input logic clock,
  input logic reset,
  iccm_loader_if.master bus
);
  localparam int NW = ADDR_W + 1;
  loader_state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, word_addr;
  logic [NW-1:0] num_q, idx_q;
  logic [31:0] chk_q, pk_word;
  logic done_q, start_acc, last, mem_req, pk_valid;
  assign start_acc = bus.start && state_q == IDLE;
  assign last = idx_q == num_q - NW'(1);
  assign word_addr = base_q + idx_q[ADDR_W-1:0];
  iccm_byte_packer u_packer (
    .clock_i(clock),
    .flush_i(reset || start_acc),
    .en_i(state_q == FILL),
    .s_valid_i(bus.s_valid),
    .s_data_i(bus.s_data),
    .s_ready_o(bus.s_ready),
    .word_valid_o(pk_valid),
    .word_o(pk_word)
  );
`ifdef ICCM_LOADER_VERIFY_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic [31:0] vsum_q, vsum_d;
  logic err_q, timeout;
  logic [ADDR_W-1:0] err_addr_q;
  assign vsum_d = vsum_q + bus.mem_rdata;
  assign timeout = tmo_q == TW'(TIMEOUT - 1);
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !bus.start ? IDLE : bus.num_words == '0 ? DONE : FILL;
      FILL: state_d = pk_valid ? WRITE : FILL;
`ifdef ICCM_LOADER_VERIFY_EN
      WRITE: state_d = last ? RD_REQ : FILL;
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: state_d = bus.mem_rvalid ? (last ? DONE : RD_REQ) : timeout ? DONE : RD_WAIT;
`else
      WRITE: state_d = last ? DONE : FILL;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      num_q <= '0;
      idx_q <= '0;
      chk_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // done trails the DONE state by a cycle so it never overlaps busy.
      done_q <= state_q == DONE;
      if (start_acc) begin
        base_q <= bus.base_addr;
        num_q <= bus.num_words;
        idx_q <= '0;
        chk_q <= '0;
      end
      if (state_q == WRITE) begin
        chk_q <= chk_q + pk_word;
        idx_q <= last ? '0 : idx_q + NW'(1);
      end
`ifdef ICCM_LOADER_VERIFY_EN
      if (state_q == RD_WAIT && bus.mem_rvalid) idx_q <= idx_q + NW'(1);
`endif
    end
  end
`ifdef ICCM_LOADER_VERIFY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_q <= '0;
      vsum_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (start_acc) begin
        vsum_q <= '0;
        err_q <= 1'b0;
        err_addr_q <= '0;
      end
      if (state_q == RD_REQ) tmo_q <= '0;
      if (state_q == RD_WAIT) begin
        tmo_q <= tmo_q + TW'(1);
        if (bus.mem_rvalid) begin
          vsum_q <= vsum_d;
          if (last && vsum_d != chk_q) begin
            err_q <= 1'b1;
            err_addr_q <= base_q;
          end
        end else if (timeout) begin
          err_q <= 1'b1;
          err_addr_q <= word_addr;
        end
      end
    end
  end
  assign bus.error = err_q;
  assign bus.err_addr = err_addr_q;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_rd;
  assign unused_rd = ^{bus.mem_rdata, bus.mem_rvalid};
  assign bus.error = 1'b0;
  assign bus.err_addr = '0;
`endif
  assign mem_req = state_q == WRITE || state_q == RD_REQ;
  assign bus.mem_req = mem_req;
  assign bus.mem_we = state_q == WRITE ? WE_FULL : WE_NONE;
  assign bus.mem_addr = mem_req ? word_addr : '0;
  assign bus.mem_wdata = state_q == WRITE ? pk_word : '0;
  assign bus.busy = state_q == FILL || state_q == WRITE || state_q == RD_REQ || state_q == RD_WAIT;
  assign bus.done = done_q;
  assign bus.checksum = chk_q;
endmodule

// File: tb/tb_iccm_loader.sv
// tb_iccm_loader: randomized scoreboard bench for iccm_loader with an ICCM model
module tb_iccm_loader;
  import iccm_loader_pkg::*;
  localparam int AW = 12;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] sum; logic err; logic [AW-1:0] eaddr;} dn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  iccm_loader_if #(.ADDR_W(AW)) bus ();
  iccm_loader #(.ADDR_W(AW), .TIMEOUT(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  logic [31:0] mem [1<<AW];
  logic corrupt = 1'b0;
  logic noresp = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  // ICCM model: writes land immediately, reads return one cycle after the request.
  always @(posedge clk) begin
    if (rst) bus.mem_rvalid <= 1'b0;
    else begin
      bus.mem_rvalid <= 1'b0;
      if (bus.mem_req && bus.mem_we == WE_FULL) mem[bus.mem_addr] <= bus.mem_wdata;
      else if (bus.mem_req && !noresp) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata <= mem[bus.mem_addr] ^ {31'd0, corrupt && bus.mem_addr == corrupt_addr};
      end
    end
  end

  always @(negedge clk) begin : mon
    wr_t e;
    dn_t d;
    if (!rst) begin
      check("busy_done_overlap", 32'(bus.busy & bus.done), 32'd0);
      if (bus.mem_req && bus.mem_we == WE_FULL) begin
        check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("wr_data", bus.mem_wdata, e.data);
        end
      end
`ifndef ICCM_LOADER_VERIFY_EN
      if (bus.mem_req) check("we_on_req", 32'(bus.mem_we), 32'(WE_FULL));
`endif
      if (bus.done) begin
        done_cnt++;
        check("done_expected", 32'(exp_dn.size() > 0), 32'd1);
        if (exp_dn.size() > 0) begin
          d = exp_dn.pop_front();
          check("checksum", bus.checksum, d.sum);
          check("error", 32'(bus.error), 32'(d.err));
          check("err_addr", 32'(bus.err_addr), 32'(d.eaddr));
        end
      end
    end
  end

  // Reference model: word j is bytes 4j..4j+3 little-endian at (base+j) mod 2^AW.
  task automatic expect_load(input logic [AW-1:0] b, input int n, input bq_t bytes);
    dn_t d;
    logic [31:0] w;
    logic [AW-1:0] off;
    d.sum = 0;
    d.err = 1'b0;
    d.eaddr = '0;
    for (int j = 0; j < n; j++) begin
      w = {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
      exp_wr.push_back('{AW'(b + j), w});
      d.sum += w;
    end
`ifdef ICCM_LOADER_VERIFY_EN
    off = corrupt_addr - b;
    if (noresp || (corrupt && int'(off) < n)) begin
      d.err = 1'b1;
      d.eaddr = b;
    end
`else
    off = '0;
`endif
    exp_dn.push_back(d);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    bus.base_addr = b;
    bus.num_words = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t bytes, input int cnt, input bit gap, input int mid_start);
    bit ok;
    int t;
    for (int i = 0; i < cnt; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = bytes[i];
      if (i == mid_start) begin
        bus.start = 1'b1;
        bus.base_addr = AW'($urandom);
        bus.num_words = 7;
      end
      t = 0;
      ok = 1'b0;
      while (!ok && t < 100) begin
        @(negedge clk);
        ok = bus.s_ready;
        @(posedge clk);
        #1 bus.start = 1'b0;
        t++;
      end
      check("byte_accept", 32'(ok), 32'd1);
      if (gap) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [AW-1:0] b, input int n, input bq_t bytes, input bit gap, input int mid_start);
    int d0 = done_cnt;
    expect_load(b, n, bytes);
    do_start(b, (AW+1)'(n));
    send_bytes(bytes, 4 * n, gap, mid_start);
    wait_done(d0);
  endtask

  task automatic rand_bytes(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t pb, rb;
    int n, d0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_checksum", bus.checksum, 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    pb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(12'h010, 2, pb, 1'b0, -1);
    check("plan_checksum", bus.checksum, 32'hCCAA8866);
    check("plan_mem0", mem[12'h010], 32'h44332211);
    check("plan_mem1", mem[12'h011], 32'h88776655);
    // Zero-length load: done two cycles after start, busy never rises.
    d0 = done_cnt;
    exp_dn.push_back('{32'd0, 1'b0, '0});
    bus.base_addr = 12'h123;
    bus.num_words = '0;
    bus.start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("zero_done_c1", {30'd0, bus.done, bus.busy | bus.mem_req}, 0);
    @(negedge clk);
    check("zero_done_c2", {30'd0, bus.done, bus.busy | bus.mem_req}, 32'd2);
    @(negedge clk);
    check("zero_done_c3", {30'd0, bus.done, bus.busy | bus.mem_req}, 0);
    check("zero_done_count", done_cnt - d0, 1);
    @(posedge clk);
    #1;
    rand_bytes(2, rb);
    run_load(12'hFFF, 2, rb, 1'b0, -1);
    run_load(12'h010, 2, pb, 1'b1, 5);
    check("toggle_mem1", mem[12'h011], 32'h88776655);
    // Reset after two bytes of the second word.
    rand_bytes(3, rb);
    expect_load(12'h200, 3, rb);
    do_start(12'h200, 13'd3);
    send_bytes(rb, 6, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", 32'(bus.mem_req), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_checksum", bus.checksum, 0);
    check("rst_mid_pending_wr", exp_wr.size(), 2);
    exp_wr.delete();
    exp_dn.delete();
    @(posedge clk);
    #1;
    rand_bytes(3, rb);
    run_load(12'h200, 3, rb, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 5);
      rand_bytes(n, rb);
      run_load(AW'($urandom), n, rb, 1'($urandom), -1);
    end
`ifdef ICCM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    corrupt_addr = 12'h011;
    run_load(12'h010, 2, pb, 1'b0, -1);
    corrupt = 1'b0;
    noresp = 1'b1;
    rand_bytes(2, rb);
    run_load(12'h300, 2, rb, 1'b0, -1);
    noresp = 1'b0;
    rand_bytes(2, rb);
    run_load(12'h400, 2, rb, 1'b0, -1);
`endif
    check("wr_queue_drained", exp_wr.size(), 0);
    check("dn_queue_drained", exp_dn.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
Initiator-side master for the single-port instruction memory (ICCM) request interface. It accepts a byte stream (e.g. from the UART/SPI boot path) and packs it little-endian into 32-bit words. It writes the words to consecutive ICCM word addresses, accumulating a 32-bit additive checksum. It sits between the boot-stream source and the ICCM port, which it owns while busy.

Parameters:
ADDR_W, 12, ICCM word-address width; addresses wrap modulo 2^ADDR_W
TIMEOUT, 8, max cycles to wait for mem_rvalid after a read request (verify only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr and num_words; ignored while busy
base_addr  in  ADDR_W  first word address
num_words  in  ADDR_W+1  words to load; 0 is legal
s_valid  in  1  byte-stream valid
s_data  in  8  byte-stream data
s_ready  out  1  byte accepted when s_valid && s_ready
busy  out  1  high from the cycle after start until DONE
done  out  1  one-cycle pulse on completion (with or without error)
error  out  1  sticky; cleared by the next accepted start
err_addr  out  ADDR_W  word address of the first failure
checksum  out  32  sum mod 2^32 of all words written
mem_req  out  1  ICCM chip enable
mem_addr  out  ADDR_W  ICCM word address
mem_wdata  out  32  ICCM write data
mem_we  out  4  ICCM write byte mask; 4'hF for writes, 4'h0 for reads
mem_rdata  in  32  ICCM read data
mem_rvalid  in  1  ICCM read valid, one cycle after a read req

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, synchronous and active-high.
- Reset values: all outputs are 0; state is IDLE. Reset mid-operation aborts immediately, discards any partial word, deasserts mem_req the next cycle, and leaves ICCM contents as already written.
- FSM states: IDLE, FILL, WRITE, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - start with num_words = 0 -> DONE. done pulses 2 cycles after start; checksum = 0.
  - start with num_words != 0 -> FILL. This clears error, checksum, and the byte and word counters.
- FILL:
  - s_ready = 1.
  - Each accepted byte k (0..3) goes to bits [8k+7:8k].
  - The 4th accepted byte -> WRITE next cycle. s_ready is 0 in that cycle.
- WRITE (exactly one cycle):
  - mem_req = 1, mem_we = 4'hF, mem_addr = base_addr + word_idx (wraps), mem_wdata = packed word.
  - checksum += word.
  - If word_idx = num_words-1: -> RD_REQ if the verify feature is compiled in, else -> DONE. Otherwise -> FILL.
  - Back-to-back bytes therefore sustain 1 word per 5 cycles.
- RD_REQ: mem_req = 1, mem_we = 0, mem_addr = base_addr + rd_idx -> RD_WAIT.
- RD_WAIT:
  - mem_req = 0.
  - On mem_rvalid: verify_sum += mem_rdata. If last word -> DONE, else -> RD_REQ.
  - If TIMEOUT cycles pass with no mem_rvalid: error = 1, err_addr = current address -> DONE.
- DONE: done = 1 for one cycle; busy = 0 -> IDLE.
- mem_req is never high outside WRITE and RD_REQ. mem_rvalid outside RD_WAIT is ignored.
- busy and done are never high in the same cycle. A start arriving in the DONE cycle is ignored.

Optional Feature:
- Macro: ICCM_LOADER_VERIFY_EN.
- Defined: after the last write, the block reads back all num_words words. It checks their sum against checksum; on mismatch it sets error = 1 and err_addr = base_addr. Read timeout is also checked.
- Undefined: RD_REQ and RD_WAIT are absent. mem_we is never 4'h0 while mem_req = 1. error can only be 0. TIMEOUT is unused.

Decomposition:
- Package iccm_loader_pkg holds:
  - state enum loader_state_e
  - WORD_BYTES = 4
  - WE_FULL = 4'hF
  - WE_NONE = 4'h0
- Natural sub-module: iccm_byte_packer. It holds the byte counter and shift-in register, drives s_ready, and outputs word_valid/word. Its flush input is driven by reset or start.

Test Plan:
- base_addr = 0x010, num_words = 2, bytes 11 22 33 44 55 66 77 88 back-to-back -> writes 0x44332211 at 0x010 and 0x88776655 at 0x011; checksum = 0xCCAA8866; one done pulse.
- num_words = 0, start -> done pulses 2 cycles later; no mem_req ever; busy low throughout.
- base_addr = 0xFFF, num_words = 2 -> writes at 0xFFF then 0x000 (wrap).
- s_valid toggling every other cycle plus start reasserted mid-load -> packing correct, second start ignored, same written data as the back-to-back case.
- Verify variant: ICCM model corrupts word at 0x011 by XOR 1 -> error = 1, err_addr = 0x010. Model never returns mem_rvalid -> error after 8 cycles in RD_WAIT, err_addr = failing address.
- reset asserted after 2 of 4 bytes of the 2nd word -> next cycle mem_req = 0, busy = 0; a new start reloads cleanly from byte 0.
